// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// The counter width covers the widest legal operand, so one package serves all instances.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MIN_WIDTH  = 2;
  localparam int MAX_WIDTH  = 64;
  localparam int MIN_DIGITS = 1;
  localparam int MAX_DIGITS = 20;
  localparam int CNT_W      = $clog2(MAX_WIDTH + 1);

  // ceil(width * log10(2)) using a fixed-point approximation of log10(2)
  function automatic int min_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit pre-shift correction: values 5..15 get +3, wrapping modulo 16.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one operand bit per clock, start/busy/done handshake,
// optional two's-complement input with separate sign, sticky overflow when DIGITS is too small.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  // With enough digits the top digit can never shift out a one.
  localparam bit CAN_OVF = (DIGITS < min_digits(WIDTH));

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("bin2bcd_seq: WIDTH %0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
  end
  if (DIGITS < MIN_DIGITS || DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS %0d outside %0d..%0d", DIGITS, MIN_DIGITS, MAX_DIGITS);
  end

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   sh_reg;
  logic [BCD_W-1:0]   acc_reg;
  logic               ovf_acc_reg;
  logic               neg_acc_reg;

  logic [WIDTH-1:0]   mag;
  logic               neg_in;
  logic [BCD_W-1:0]   adj;

  // Magnitude of the operand; the most negative value negates onto itself,
  // which read as unsigned is exactly 2^(WIDTH-1).
  always_comb begin
    mag    = bin;
    neg_in = 1'b0;
    if (SIGNED != 0 && bin[WIDTH-1]) begin
      mag    = ~bin + WIDTH'(1);
      neg_in = 1'b1;
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit_adj u_adj (
      .digit    (acc_reg[4*gi +: 4]),
      .adjusted (adj[4*gi +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      sh_reg      <= '0;
      acc_reg     <= '0;
      ovf_acc_reg <= 1'b0;
      neg_acc_reg <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd         <= '0;
      neg         <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_reg   <= SHIFT;
            busy        <= 1'b1;
            sh_reg      <= mag;
            acc_reg     <= '0;
            ovf_acc_reg <= 1'b0;
            neg_acc_reg <= neg_in;
            cnt_reg     <= CNT_W'(WIDTH);
          end
        end
        SHIFT: begin
          if (cnt_reg != '0) begin
            acc_reg <= {adj[BCD_W-2:0], sh_reg[WIDTH-1]};
            sh_reg  <= {sh_reg[WIDTH-2:0], 1'b0};
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (CAN_OVF && adj[BCD_W-1]) begin
              ovf_acc_reg <= 1'b1;
            end
          end else begin
            // Counter exhausted: publish results as DONE is entered so they are
            // visible together with the done pulse.
            state_reg <= DONE;
            bcd       <= acc_reg;
            neg       <= neg_acc_reg;
            ovf       <= ovf_acc_reg;
            done      <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: four parameterisations share clock and reset,
// each conversion is checked against hand-computed BCD values and latencies.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_v [4];
  logic [63:0] bin_v [4];
  logic busy_w [4];
  logic done_w [4];
  logic neg_w [4];
  logic ovf_w [4];
  logic [11:0] bcd0;
  logic [39:0] bcd1;
  logic [11:0] bcd2;
  logic [7:0]  bcd3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // 0: 8b/3 digits unsigned, 1: 32b/10 digits, 2: 8b/3 digits signed, 3: 8b/2 digits
  bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u_w8 (
    .clk(clk), .reset(reset), .start(start_v[0]), .bin(bin_v[0][7:0]),
    .busy(busy_w[0]), .done(done_w[0]), .bcd(bcd0), .neg(neg_w[0]), .ovf(ovf_w[0]));
  bin2bcd_seq #(.WIDTH(32), .DIGITS(10), .SIGNED(0)) u_w32 (
    .clk(clk), .reset(reset), .start(start_v[1]), .bin(bin_v[1][31:0]),
    .busy(busy_w[1]), .done(done_w[1]), .bcd(bcd1), .neg(neg_w[1]), .ovf(ovf_w[1]));
  bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_s8 (
    .clk(clk), .reset(reset), .start(start_v[2]), .bin(bin_v[2][7:0]),
    .busy(busy_w[2]), .done(done_w[2]), .bcd(bcd2), .neg(neg_w[2]), .ovf(ovf_w[2]));
  bin2bcd_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) u_d2 (
    .clk(clk), .reset(reset), .start(start_v[3]), .bin(bin_v[3][7:0]),
    .busy(busy_w[3]), .done(done_w[3]), .bcd(bcd3), .neg(neg_w[3]), .ovf(ovf_w[3]));

  function automatic logic [79:0] bcd_of(input int id);
    case (id)
      0:       return 80'(bcd0);
      1:       return 80'(bcd1);
      2:       return 80'(bcd2);
      default: return 80'(bcd3);
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, then follow the conversion until busy drops.
  // lat = cycles after the accepting edge at which done is seen (-1 if never).
  task automatic run(input int id, input logic [63:0] v, output int lat,
                     output int busy_cnt, output int done_cnt);
    @(negedge clk);
    start_v[id] = 1'b1;
    bin_v[id]   = v;
    @(posedge clk);
    @(negedge clk);
    start_v[id] = 1'b0;
    bin_v[id]   = 64'hA5A5_A5A5_A5A5_A5A5;
    lat = -1;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      if (busy_w[id]) busy_cnt++;
      if (done_w[id]) begin
        done_cnt++;
        if (lat < 0) lat = k;
      end
      if (!busy_w[id]) break;
    end
    $display("conv id=%0d bin=%0h bcd=%0h neg=%0b ovf=%0b lat=%0d busy=%0d",
             id, v, bcd_of(id), neg_w[id], ovf_w[id], lat, busy_cnt);
  endtask

  initial begin
    int lat, bc, dc;
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0;
      bin_v[i]   = '0;
    end
    repeat (3) @(negedge clk);
    // start asserted during reset must not launch anything
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rst_flags%0d", i),
               80'({busy_w[i], done_w[i], neg_w[i], ovf_w[i]}), 80'h0);
      check_eq($sformatf("rst_bcd%0d", i), bcd_of(i), 80'h0);
    end

    // 8-bit unsigned full scale
    run(0, 64'd255, lat, bc, dc);
    check_eq("w8_255_bcd", bcd_of(0), 80'h255);
    check_eq("w8_255_lat", 80'(lat), 80'd9);
    check_eq("w8_255_busy", 80'(bc), 80'd10);
    check_eq("w8_255_flags", 80'({neg_w[0], ovf_w[0], done_w[0]}), 80'h0);

    // 32-bit full scale and zero
    run(1, 64'hFFFF_FFFF, lat, bc, dc);
    check_eq("w32_max_bcd", bcd_of(1), 80'h42_9496_7295);
    check_eq("w32_max_lat", 80'(lat), 80'd33);
    run(1, 64'd0, lat, bc, dc);
    check_eq("w32_zero_bcd", bcd_of(1), 80'h0);
    check_eq("w32_zero_lat", 80'(lat), 80'd33);

    // signed operands, including the most negative value
    run(2, 64'h80, lat, bc, dc);
    check_eq("s8_80_bcd", bcd_of(2), 80'h128);
    check_eq("s8_80_neg", 80'(neg_w[2]), 80'h1);
    check_eq("s8_80_ovf", 80'(ovf_w[2]), 80'h0);
    run(2, 64'hFF, lat, bc, dc);
    check_eq("s8_ff_bcd", bcd_of(2), 80'h001);
    check_eq("s8_ff_neg", 80'(neg_w[2]), 80'h1);
    run(2, 64'h7F, lat, bc, dc);
    check_eq("s8_7f_bcd", bcd_of(2), 80'h127);
    check_eq("s8_7f_neg", 80'(neg_w[2]), 80'h0);

    // too few digits: overflow, then a fitting value clears it
    run(3, 64'd255, lat, bc, dc);
    check_eq("d2_255_bcd", bcd_of(3), 80'h55);
    check_eq("d2_255_ovf", 80'(ovf_w[3]), 80'h1);
    run(3, 64'd99, lat, bc, dc);
    check_eq("d2_99_bcd", bcd_of(3), 80'h99);
    check_eq("d2_99_ovf", 80'(ovf_w[3]), 80'h0);

    // start while busy, and start during the done cycle, are both ignored
    @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 64'd200;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 64'd5;
    @(negedge clk);
    start_v[0] = 1'b0;
    dc = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_w[0]) begin
        dc++;
        check_eq("ovl_bcd_at_done", bcd_of(0), 80'h200);
        bin_v[0] = 64'd7;
      end
      start_v[0] = done_w[0];
    end
    start_v[0] = 1'b0;
    $display("conv id=0 overlap done_count=%0d bcd=%0h", dc, bcd_of(0));
    check_eq("ovl_done_count", 80'(dc), 80'd1);
    check_eq("ovl_idle_after", 80'(busy_w[0]), 80'h0);
    check_eq("ovl_bcd_held", bcd_of(0), 80'h200);

    // reset four cycles into a conversion
    @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 64'd150;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("conv id=0 aborted by reset busy=%0b bcd=%0h", busy_w[0], bcd_of(0));
    check_eq("abort_busy_done", 80'({busy_w[0], done_w[0]}), 80'h0);
    check_eq("abort_bcd", bcd_of(0), 80'h0);
    run(0, 64'd77, lat, bc, dc);
    check_eq("after_abort_bcd", bcd_of(0), 80'h077);
    check_eq("after_abort_lat", 80'(lat), 80'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
